// File: rtl/bp_vcache_mem_responder.sv
// Memory-side responder with a small exclusive victim buffer of writeback blocks.
// Read hits are served locally; misses, evictions and uncached traffic go downstream.
module bp_vcache_mem_responder #(
  parameter int paddr_width_p = 40,
  parameter int block_width_p = 512,
  parameter int entries_p     = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,

  input  logic [1:0]               mem_cmd_type_i,
  input  logic [paddr_width_p-1:0] mem_cmd_addr_i,
  input  logic [block_width_p-1:0] mem_cmd_data_i,
  input  logic                     mem_cmd_v_i,
  output logic                     mem_cmd_ready_o,

  output logic [1:0]               mem_resp_type_o,
  output logic [paddr_width_p-1:0] mem_resp_addr_o,
  output logic [block_width_p-1:0] mem_resp_data_o,
  output logic                     mem_resp_v_o,
  input  logic                     mem_resp_yumi_i,

  output logic [1:0]               dn_cmd_type_o,
  output logic [paddr_width_p-1:0] dn_cmd_addr_o,
  output logic [block_width_p-1:0] dn_cmd_data_o,
  output logic                     dn_cmd_v_o,
  input  logic                     dn_cmd_ready_i,

  input  logic [1:0]               dn_resp_type_i,
  input  logic [paddr_width_p-1:0] dn_resp_addr_i,
  input  logic [block_width_p-1:0] dn_resp_data_i,
  input  logic                     dn_resp_v_i,
  output logic                     dn_resp_yumi_o
);

  localparam int offset_width_lp = $clog2(block_width_p/8);
  localparam int idx_width_lp    = $clog2(entries_p);

  localparam logic [1:0] cmd_rd_lp    = 2'd0;
  localparam logic [1:0] cmd_wb_lp    = 2'd1;
  localparam logic [1:0] cmd_uc_wr_lp = 2'd3;

  typedef enum logic [2:0] {
    READY      = 3'd0,
    EVICT_CMD  = 3'd1,
    EVICT_WAIT = 3'd2,
    FWD_CMD    = 3'd3,
    FWD_WAIT   = 3'd4,
    RESP       = 3'd5
  } state_e;

  function automatic logic [paddr_width_p-1:0] block_addr(input logic [paddr_width_p-1:0] addr);
    block_addr = {addr[paddr_width_p-1:offset_width_lp], {offset_width_lp{1'b0}}};
  endfunction

  state_e state_q, state_d;
  logic [entries_p-1:0]     valid_q, valid_d;
  logic [paddr_width_p-1:0] tag_q [entries_p];
  logic [paddr_width_p-1:0] tag_d [entries_p];
  logic [block_width_p-1:0] data_q [entries_p];
  logic [block_width_p-1:0] data_d [entries_p];
  logic [idx_width_lp-1:0]  ptr_q, ptr_d;

  logic                     ready_q, ready_d;
  logic                     resp_v_q, resp_v_d;
  logic [1:0]               resp_type_q, resp_type_d;
  logic [paddr_width_p-1:0] resp_addr_q, resp_addr_d;
  logic [block_width_p-1:0] resp_data_q, resp_data_d;
  logic [block_width_p-1:0] cmd_data_q, cmd_data_d;
  logic                     dn_v_q, dn_v_d;
  logic [1:0]               dn_type_q, dn_type_d;
  logic [paddr_width_p-1:0] dn_addr_q, dn_addr_d;
  logic [block_width_p-1:0] dn_data_q, dn_data_d;

  logic                     hit_s, free_s;
  logic [idx_width_lp-1:0]  hit_idx_s, free_idx_s;

  logic unused_dn_resp_s;
  assign unused_dn_resp_s = ^{dn_resp_type_i, dn_resp_addr_i};

  // Buffer lookup on the incoming command: matching entry and lowest-index free entry.
  always_comb begin
    hit_s      = 1'b0;
    hit_idx_s  = '0;
    free_s     = 1'b0;
    free_idx_s = '0;
    for (int i = entries_p-1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_s     = 1'b1;
        free_idx_s = idx_width_lp'(i);
      end else if (tag_q[i] == block_addr(mem_cmd_addr_i)) begin
        hit_s     = 1'b1;
        hit_idx_s = idx_width_lp'(i);
      end else begin
        hit_s = hit_s;
      end
    end
  end

  // Next-state, buffer update and output-register logic.
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    tag_d       = tag_q;
    data_d      = data_q;
    ptr_d       = ptr_q;
    resp_type_d = resp_type_q;
    resp_addr_d = resp_addr_q;
    resp_data_d = resp_data_q;
    cmd_data_d  = cmd_data_q;
    dn_type_d   = dn_type_q;
    dn_addr_d   = dn_addr_q;
    dn_data_d   = dn_data_q;

    case (state_q)
      READY: begin
        if (mem_cmd_v_i && ready_q) begin
          resp_type_d = mem_cmd_type_i;
          resp_addr_d = mem_cmd_addr_i;
          resp_data_d = '0;
          cmd_data_d  = mem_cmd_data_i;
          if (mem_cmd_type_i == cmd_rd_lp && hit_s) begin
            resp_data_d        = data_q[hit_idx_s];
            valid_d[hit_idx_s] = 1'b0;
            state_d            = RESP;
          end else if (mem_cmd_type_i == cmd_wb_lp) begin
            if (hit_s) begin
              data_d[hit_idx_s] = mem_cmd_data_i;
              state_d           = RESP;
            end else if (free_s) begin
              valid_d[free_idx_s] = 1'b1;
              tag_d[free_idx_s]   = block_addr(mem_cmd_addr_i);
              data_d[free_idx_s]  = mem_cmd_data_i;
              state_d             = RESP;
            end else begin
              dn_type_d = cmd_wb_lp;
              dn_addr_d = tag_q[ptr_q];
              dn_data_d = data_q[ptr_q];
              state_d   = EVICT_CMD;
            end
          end else begin
            // Read misses and all uncached ops bypass the buffer entirely.
            dn_type_d = mem_cmd_type_i;
            dn_addr_d = mem_cmd_addr_i;
            dn_data_d = (mem_cmd_type_i == cmd_uc_wr_lp) ? mem_cmd_data_i : '0;
            state_d   = FWD_CMD;
          end
        end else begin
          state_d = READY;
        end
      end
      EVICT_CMD: begin
        if (dn_cmd_ready_i) state_d = EVICT_WAIT;
        else                state_d = EVICT_CMD;
      end
      EVICT_WAIT: begin
        if (dn_resp_v_i) begin
          valid_d[ptr_q] = 1'b1;
          tag_d[ptr_q]   = block_addr(resp_addr_q);
          data_d[ptr_q]  = cmd_data_q;
          ptr_d          = ptr_q + idx_width_lp'(1);
          resp_data_d    = '0;
          state_d        = RESP;
        end else begin
          state_d = EVICT_WAIT;
        end
      end
      FWD_CMD: begin
        if (dn_cmd_ready_i) state_d = FWD_WAIT;
        else                state_d = FWD_CMD;
      end
      FWD_WAIT: begin
        if (dn_resp_v_i) begin
          resp_data_d = (resp_type_q == cmd_uc_wr_lp) ? '0 : dn_resp_data_i;
          state_d     = RESP;
        end else begin
          state_d = FWD_WAIT;
        end
      end
      RESP: begin
        if (mem_resp_yumi_i) state_d = READY;
        else                 state_d = RESP;
      end
      default: state_d = READY;
    endcase

    ready_d  = (state_d == READY);
    resp_v_d = (state_d == RESP);
    dn_v_d   = (state_d == EVICT_CMD) || (state_d == FWD_CMD);
  end

  // State, buffer and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q     <= READY;
      valid_q     <= '0;
      for (int i = 0; i < entries_p; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
      ptr_q       <= '0;
      ready_q     <= 1'b0;
      resp_v_q    <= 1'b0;
      resp_type_q <= 2'd0;
      resp_addr_q <= '0;
      resp_data_q <= '0;
      cmd_data_q  <= '0;
      dn_v_q      <= 1'b0;
      dn_type_q   <= 2'd0;
      dn_addr_q   <= '0;
      dn_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      tag_q       <= tag_d;
      data_q      <= data_d;
      ptr_q       <= ptr_d;
      ready_q     <= ready_d;
      resp_v_q    <= resp_v_d;
      resp_type_q <= resp_type_d;
      resp_addr_q <= resp_addr_d;
      resp_data_q <= resp_data_d;
      cmd_data_q  <= cmd_data_d;
      dn_v_q      <= dn_v_d;
      dn_type_q   <= dn_type_d;
      dn_addr_q   <= dn_addr_d;
      dn_data_q   <= dn_data_d;
    end
  end

  assign mem_cmd_ready_o = ready_q;
  assign mem_resp_v_o    = resp_v_q;
  assign mem_resp_type_o = resp_type_q;
  assign mem_resp_addr_o = resp_addr_q;
  assign mem_resp_data_o = resp_data_q;
  assign dn_cmd_v_o      = dn_v_q;
  assign dn_cmd_type_o   = dn_type_q;
  assign dn_cmd_addr_o   = dn_addr_q;
  assign dn_cmd_data_o   = dn_data_q;
  assign dn_resp_yumi_o  = dn_resp_v_i && ((state_q == EVICT_WAIT) || (state_q == FWD_WAIT));

endmodule
